// File: rtl/control_pkg.sv
// Shared types for the RV32I multi-cycle controller: FSM states, datapath
// select encodings, instruction classes and base opcodes.
package control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } e_ctrl_state;

    // Encoded as {funct7[5], funct3} so OP/OP-IMM map straight onto it.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } e_alu_operation_sel;

    typedef enum logic [1:0] {
        ALU_RS1  = 2'd0,
        ALU_PC   = 2'd1,
        ALU_ZERO = 2'd2
    } e_alu_operand_a_sel;

    typedef enum logic {
        ALU_RS2 = 1'b0,
        ALU_IMM = 1'b1
    } e_alu_operand_b_sel;

    typedef enum logic [1:0] {
        WB_ALU_OUT  = 2'd0,
        WB_MEM_LOAD = 2'd1,
        WB_PC_PLS4  = 2'd2
    } e_regfile_wb_sel;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JAL    = 2'd2,
        PC_JALR   = 2'd3
    } e_pc_next_sel;

    typedef enum logic [3:0] {
        CLS_OP,
        CLS_OP_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_ILLEGAL
    } e_insn_class;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        e_insn_class        cls;
        e_alu_operation_sel alu_op;
        e_alu_operand_a_sel a_sel;
        e_alu_operand_b_sel b_sel;
        e_regfile_wb_sel    wb_sel;
        logic               illegal;
    } s_decode;

    // Branch compare op: equality via SUB, signed via SLT, unsigned via SLTU.
    function automatic e_alu_operation_sel branch_alu_op(input logic [2:0] funct3);
        case (funct3[2:1])
            2'b10:   return ALU_SLT;
            2'b11:   return ALU_SLTU;
            default: return ALU_SUB;
        endcase
    endfunction

endpackage

// File: rtl/core_ctrl_fsm_decode.sv
// Combinational IR decoder: instruction class, ALU op and operand selects,
// writeback select and illegal-instruction flag.
module core_ctrl_decode
    import control_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_instr,
    output s_decode         o_dec
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unused_bits;

    assign w_opcode      = i_instr[6:0];
    assign w_funct3      = i_instr[14:12];
    assign w_funct7      = i_instr[31:25];
    assign w_unused_bits = ^{i_instr[24:15], i_instr[11:7]};

    // Classify the IR and derive the datapath selects for its class.
    always_comb begin
        // NOTE: every field gets a default before the case so no path infers a latch.
        o_dec.cls     = CLS_ILLEGAL;
        o_dec.alu_op  = ALU_ADD;
        o_dec.a_sel   = ALU_RS1;
        o_dec.b_sel   = ALU_RS2;
        o_dec.wb_sel  = WB_ALU_OUT;
        o_dec.illegal = 1'b1;
        case (w_opcode)
            OPC_OP: begin
                o_dec.cls     = CLS_OP;
                o_dec.alu_op  = e_alu_operation_sel'({w_funct7[5], w_funct3});
                // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
                o_dec.illegal = !((w_funct7 == 7'b0000000) ||
                                  ((w_funct7 == 7'b0100000) &&
                                   ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
            end
            OPC_OP_IMM: begin
                o_dec.cls     = CLS_OP_IMM;
                o_dec.b_sel   = ALU_IMM;
                o_dec.illegal = 1'b0;
                // Upper immediate bits are data, not funct7, except for shifts.
                o_dec.alu_op  = e_alu_operation_sel'({1'b0, w_funct3});
                if (w_funct3 == 3'b101) begin
                    o_dec.alu_op  = e_alu_operation_sel'({w_funct7[5], w_funct3});
                    o_dec.illegal = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
                end else if (w_funct3 == 3'b001) begin
                    o_dec.illegal = (w_funct7 != 7'b0000000);
                end
            end
            OPC_LOAD: begin
                o_dec.cls     = CLS_LOAD;
                o_dec.b_sel   = ALU_IMM;
                o_dec.wb_sel  = WB_MEM_LOAD;
                o_dec.illegal = 1'b0;
            end
            OPC_STORE: begin
                o_dec.cls     = CLS_STORE;
                o_dec.b_sel   = ALU_IMM;
                o_dec.illegal = 1'b0;
            end
            OPC_BRANCH: begin
                o_dec.cls     = CLS_BRANCH;
                o_dec.alu_op  = branch_alu_op(w_funct3);
                o_dec.illegal = 1'b0;
            end
            OPC_JAL: begin
                o_dec.cls     = CLS_JAL;
                o_dec.a_sel   = ALU_PC;
                o_dec.b_sel   = ALU_IMM;
                o_dec.wb_sel  = WB_PC_PLS4;
                o_dec.illegal = 1'b0;
            end
            OPC_JALR: begin
                o_dec.cls     = CLS_JALR;
                o_dec.b_sel   = ALU_IMM;
                o_dec.wb_sel  = WB_PC_PLS4;
                o_dec.illegal = 1'b0;
            end
            OPC_LUI: begin
                o_dec.cls     = CLS_LUI;
                o_dec.a_sel   = ALU_ZERO;
                o_dec.b_sel   = ALU_IMM;
                o_dec.illegal = 1'b0;
            end
            OPC_AUIPC: begin
                o_dec.cls     = CLS_AUIPC;
                o_dec.a_sel   = ALU_PC;
                o_dec.b_sel   = ALU_IMM;
                o_dec.illegal = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32I main controller: FETCH/DECODE/EXECUTE/MEM/WB with a
// sticky TRAP state. Define CTRL_PERF_CNT_EN to add mcycle/minstret counters.
module core_ctrl_fsm
    import control_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_o,
    input  logic               imem_rvalid_i,
    input  logic [XLEN-1:0]    instr_i,
    output logic               ir_we_o,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    input  logic               dmem_rvalid_i,
    input  logic               branch_taken_i,
    output e_alu_operation_sel alu_op_o,
    output e_alu_operand_a_sel alu_a_sel_o,
    output e_alu_operand_b_sel alu_b_sel_o,
    output e_regfile_wb_sel    wb_sel_o,
    output logic               rf_we_o,
    output logic               pc_we_o,
    output e_pc_next_sel       pc_sel_o,
    output logic               illegal_insn_o
`ifdef CTRL_PERF_CNT_EN
   ,output logic [CNT_W-1:0]   mcycle_o,
    output logic [CNT_W-1:0]   minstret_o
`endif
);

    e_ctrl_state r_state;
    s_decode     w_dec;
    logic        w_is_store;

    core_ctrl_decode #(.XLEN(XLEN)) u_decode (
        .i_instr (instr_i),
        .o_dec   (w_dec)
    );

    assign w_is_store = (w_dec.cls == CLS_STORE);

    // State register: advances on memory handshakes, one cycle elsewhere.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH:   if (imem_rvalid_i) r_state <= ST_DECODE;
                ST_DECODE:  r_state <= w_dec.illegal ? ST_TRAP : ST_EXECUTE;
                ST_EXECUTE: begin
                    case (w_dec.cls)
                        CLS_BRANCH:           r_state <= ST_FETCH;
                        CLS_LOAD, CLS_STORE:  r_state <= ST_MEM;
                        default:              r_state <= ST_WB;
                    endcase
                end
                ST_MEM:     if (dmem_rvalid_i) r_state <= w_is_store ? ST_FETCH : ST_WB;
                ST_WB:      r_state <= ST_FETCH;
                ST_TRAP:    r_state <= ST_TRAP;
                default:    r_state <= ST_FETCH;
            endcase
        end
    end

    // Datapath controls from state + IR; reset forces the idle defaults.
    always_comb begin
        imem_req_o     = 1'b0;
        ir_we_o        = 1'b0;
        dmem_req_o     = 1'b0;
        dmem_we_o      = 1'b0;
        rf_we_o        = 1'b0;
        pc_we_o        = 1'b0;
        illegal_insn_o = 1'b0;
        alu_op_o       = ALU_ADD;
        alu_a_sel_o    = ALU_RS1;
        alu_b_sel_o    = ALU_RS2;
        wb_sel_o       = WB_ALU_OUT;
        pc_sel_o       = PC_PLUS4;
        if (!rst) begin
            // ALU selects are set in EXECUTE and held through MEM and WB.
            if (r_state inside {ST_EXECUTE, ST_MEM, ST_WB}) begin
                alu_op_o    = w_dec.alu_op;
                alu_a_sel_o = w_dec.a_sel;
                alu_b_sel_o = w_dec.b_sel;
            end
            case (r_state)
                ST_FETCH: begin
                    imem_req_o = 1'b1;
                    ir_we_o    = imem_rvalid_i;
                end
                ST_EXECUTE: begin
                    if (w_dec.cls == CLS_BRANCH) begin
                        pc_we_o  = 1'b1;
                        pc_sel_o = branch_taken_i ? PC_BRANCH : PC_PLUS4;
                    end
                end
                ST_MEM: begin
                    dmem_req_o = 1'b1;
                    dmem_we_o  = w_is_store;
                    pc_we_o    = dmem_rvalid_i && w_is_store;
                end
                ST_WB: begin
                    rf_we_o  = 1'b1;
                    pc_we_o  = 1'b1;
                    wb_sel_o = w_dec.wb_sel;
                    if (w_dec.cls == CLS_JAL) begin
                        pc_sel_o = PC_JAL;
                    end else if (w_dec.cls == CLS_JALR) begin
                        pc_sel_o = PC_JALR;
                    end
                end
                ST_TRAP: illegal_insn_o = 1'b1;
                default: begin
                end
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_mcycle;
    logic [CNT_W-1:0] r_minstret;

    // Free-running cycle count and retired-instruction count; both wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            r_mcycle <= r_mcycle + CNT_W'(1);
            if (pc_we_o) begin
                r_minstret <= r_minstret + CNT_W'(1);
            end
        end
    end

    assign mcycle_o   = r_mcycle;
    assign minstret_o = r_minstret;
`else
    logic [CNT_W-1:0] w_unused_cnt_w;
    assign w_unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Scoreboard bench for core_ctrl_fsm: the driver pushes the expected retire
// record per instruction, a monitor pops it on every pc_we pulse.
module tb_core_ctrl_fsm;
    import control_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 64;

    logic               clk;
    logic               rst;
    logic               imem_req_o;
    logic               imem_rvalid_i;
    logic [XLEN-1:0]    instr_i;
    logic               ir_we_o;
    logic               dmem_req_o;
    logic               dmem_we_o;
    logic               dmem_rvalid_i;
    logic               branch_taken_i;
    e_alu_operation_sel alu_op_o;
    e_alu_operand_a_sel alu_a_sel_o;
    e_alu_operand_b_sel alu_b_sel_o;
    e_regfile_wb_sel    wb_sel_o;
    logic               rf_we_o;
    logic               pc_we_o;
    e_pc_next_sel       pc_sel_o;
    logic               illegal_insn_o;
`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0]   mcycle_o;
    logic [CNT_W-1:0]   minstret_o;
`endif

    core_ctrl_fsm #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_o     (imem_req_o),
        .imem_rvalid_i  (imem_rvalid_i),
        .instr_i        (instr_i),
        .ir_we_o        (ir_we_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .branch_taken_i (branch_taken_i),
        .alu_op_o       (alu_op_o),
        .alu_a_sel_o    (alu_a_sel_o),
        .alu_b_sel_o    (alu_b_sel_o),
        .wb_sel_o       (wb_sel_o),
        .rf_we_o        (rf_we_o),
        .pc_we_o        (pc_we_o),
        .pc_sel_o       (pc_sel_o),
        .illegal_insn_o (illegal_insn_o)
`ifdef CTRL_PERF_CNT_EN
       ,.mcycle_o       (mcycle_o),
        .minstret_o     (minstret_o)
`endif
    );

    typedef struct {
        string              name;
        logic               rf_we;
        e_regfile_wb_sel    wb;
        e_pc_next_sel       pc;
        e_alu_operation_sel op;
        e_alu_operand_a_sel a;
        e_alu_operand_b_sel b;
        logic               mwe;
        int                 lat;
        int                 issue;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_checks = 0;
    int   n_retired = 0;
    int   cyc = 0;
    int   dmem_delay = 0;
    int   dmem_wait = 0;
    int   dmem_req_cycles = 0;
    logic dmem_we_or = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t mk(input string name, input logic rf_we, input e_regfile_wb_sel wb,
                                input e_pc_next_sel pc, input e_alu_operation_sel op,
                                input e_alu_operand_a_sel a, input e_alu_operand_b_sel b,
                                input logic mwe, input int lat);
        exp_t e;
        e.name = name; e.rf_we = rf_we; e.wb = wb; e.pc = pc; e.op = op;
        e.a = a; e.b = b; e.mwe = mwe; e.lat = lat; e.issue = 0;
        return e;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Data memory responder: answers each request after dmem_delay wait cycles.
    initial begin
        dmem_rvalid_i = 1'b0;
        forever begin
            @(negedge clk);
            if (dmem_req_o) begin
                dmem_req_cycles++;
                dmem_we_or = dmem_we_or | dmem_we_o;
                if (dmem_wait >= dmem_delay) begin
                    dmem_rvalid_i = 1'b1;
                    dmem_wait     = 0;
                end else begin
                    dmem_rvalid_i = 1'b0;
                    dmem_wait++;
                end
            end else begin
                dmem_rvalid_i = 1'b0;
                dmem_wait     = 0;
            end
        end
    end

    // Monitor: every pc_we pulse retires the oldest expected instruction.
    initial begin : monitor
        exp_t m;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (pc_we_o) begin
                    if (sb.size() == 0) begin
                        check("spurious_pc_we", pc_we_o, 1'b0);
                    end else begin
                        m = sb.pop_front();
                        n_retired++;
                        check({m.name, " rf_we"}, rf_we_o, m.rf_we);
                        if (m.rf_we) check({m.name, " wb_sel"}, wb_sel_o, m.wb);
                        check({m.name, " pc_sel"}, pc_sel_o, m.pc);
                        check({m.name, " held_alu_op"}, alu_op_o, m.op);
                        check({m.name, " dmem_we"}, dmem_we_o, m.mwe);
                        check({m.name, " latency"}, cyc - m.issue + 1, m.lat);
                    end
                end else if (rf_we_o) begin
                    check("rf_we_without_pc_we", rf_we_o, 1'b0);
                end
            end
        end
    end

    task automatic do_reset(input string name);
        rst           = 1'b1;
        imem_rvalid_i = 1'b0;
        @(negedge clk);
        #1;
        check({name, " rst_imem_req"}, imem_req_o, 1'b0);
`ifdef CTRL_PERF_CNT_EN
        check({name, " rst_mcycle"}, mcycle_o, '0);
        check({name, " rst_minstret"}, minstret_o, '0);
`endif
        rst = 1'b0;
        #1;
        check({name, " post_rst_fetch_req"}, imem_req_o, 1'b1);
        check({name, " post_rst_illegal"}, illegal_insn_o, 1'b0);
    endtask

    task automatic run_insn(input logic [31:0] insn, input logic taken, input int delay,
                            input exp_t e);
        exp_t t;
        logic done;
        t = e;
        check({e.name, " fetch_req"}, imem_req_o, 1'b1);
        dmem_delay      = delay;
        dmem_req_cycles = 0;
        dmem_we_or      = 1'b0;
        branch_taken_i  = taken;
        instr_i         = insn;
        imem_rvalid_i   = 1'b1;
        t.issue         = cyc;
        sb.push_back(t);
        #1;
        check({e.name, " ir_we"}, ir_we_o, 1'b1);
        @(negedge clk);
        #1;
        imem_rvalid_i = 1'b0;
        @(negedge clk);
        #1;
        check({e.name, " exec_alu_op"}, alu_op_o, e.op);
        check({e.name, " exec_a_sel"}, alu_a_sel_o, e.a);
        check({e.name, " exec_b_sel"}, alu_b_sel_o, e.b);
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            #1;
            done = imem_req_o;
        end
        check({e.name, " back_to_fetch"}, done, 1'b1);
        check({e.name, " retired_once"}, sb.size(), 0);
    endtask

    task automatic run_trap(input string name, input logic [31:0] insn);
        check({name, " fetch_req"}, imem_req_o, 1'b1);
        instr_i       = insn;
        imem_rvalid_i = 1'b1;
        @(negedge clk);
        #1;
        imem_rvalid_i = 1'b0;
        check({name, " decode_not_trapped"}, illegal_insn_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            imem_rvalid_i = 1'b1;
            #1;
            check({name, " trap_illegal"}, illegal_insn_o, 1'b1);
            check({name, " trap_no_imem_req"}, imem_req_o, 1'b0);
            check({name, " trap_no_pc_we"}, pc_we_o, 1'b0);
            check({name, " trap_no_ir_we"}, ir_we_o, 1'b0);
        end
        do_reset(name);
    endtask

    initial begin : stimulus
        logic done;
        rst            = 1'b1;
        imem_rvalid_i  = 1'b0;
        instr_i        = '0;
        branch_taken_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset imem_req", imem_req_o, 1'b0);
        check("reset dmem_req", dmem_req_o, 1'b0);
        check("reset rf_we", rf_we_o, 1'b0);
        check("reset pc_we", pc_we_o, 1'b0);
        check("reset alu_op", alu_op_o, ALU_ADD);
        check("reset a_sel", alu_a_sel_o, ALU_RS1);
        check("reset b_sel", alu_b_sel_o, ALU_RS2);
        check("reset wb_sel", wb_sel_o, WB_ALU_OUT);
        check("reset pc_sel", pc_sel_o, PC_PLUS4);
        check("reset illegal", illegal_insn_o, 1'b0);
        do_reset("init");

        run_insn(32'h002081B3, 1'b0, 0, mk("add",   1, WB_ALU_OUT,  PC_PLUS4,  ALU_ADD,  ALU_RS1,  ALU_RS2, 0, 4));
        run_insn(32'h40208133, 1'b0, 0, mk("sub",   1, WB_ALU_OUT,  PC_PLUS4,  ALU_SUB,  ALU_RS1,  ALU_RS2, 0, 4));
        run_insn(32'h0020A1B3, 1'b0, 0, mk("slt",   1, WB_ALU_OUT,  PC_PLUS4,  ALU_SLT,  ALU_RS1,  ALU_RS2, 0, 4));
        run_insn(32'h40315093, 1'b0, 0, mk("srai",  1, WB_ALU_OUT,  PC_PLUS4,  ALU_SRA,  ALU_RS1,  ALU_IMM, 0, 4));
        run_insn(32'h40010093, 1'b0, 0, mk("addi",  1, WB_ALU_OUT,  PC_PLUS4,  ALU_ADD,  ALU_RS1,  ALU_IMM, 0, 4));
        run_insn(32'h0080A283, 1'b0, 3, mk("lw_w3", 1, WB_MEM_LOAD, PC_PLUS4,  ALU_ADD,  ALU_RS1,  ALU_IMM, 0, 8));
        check("lw_w3 dmem_req_cycles", dmem_req_cycles, 4);
        check("lw_w3 dmem_we_seen", dmem_we_or, 1'b0);
        run_insn(32'h0020A223, 1'b0, 0, mk("sw",    0, WB_ALU_OUT,  PC_PLUS4,  ALU_ADD,  ALU_RS1,  ALU_IMM, 1, 4));
        check("sw dmem_req_cycles", dmem_req_cycles, 1);
        run_insn(32'h00208463, 1'b1, 0, mk("beq_t", 0, WB_ALU_OUT,  PC_BRANCH, ALU_SUB,  ALU_RS1,  ALU_RS2, 0, 3));
        run_insn(32'h00208463, 1'b0, 0, mk("beq_n", 0, WB_ALU_OUT,  PC_PLUS4,  ALU_SUB,  ALU_RS1,  ALU_RS2, 0, 3));
        run_insn(32'h0020E463, 1'b1, 0, mk("bltu",  0, WB_ALU_OUT,  PC_BRANCH, ALU_SLTU, ALU_RS1,  ALU_RS2, 0, 3));
        run_insn(32'h0020D463, 1'b0, 0, mk("bge",   0, WB_ALU_OUT,  PC_PLUS4,  ALU_SLT,  ALU_RS1,  ALU_RS2, 0, 3));
        run_insn(32'h010000EF, 1'b0, 0, mk("jal",   1, WB_PC_PLS4,  PC_JAL,    ALU_ADD,  ALU_PC,   ALU_IMM, 0, 4));
        run_insn(32'h000100E7, 1'b0, 0, mk("jalr",  1, WB_PC_PLS4,  PC_JALR,   ALU_ADD,  ALU_RS1,  ALU_IMM, 0, 4));
        run_insn(32'h123452B7, 1'b0, 0, mk("lui",   1, WB_ALU_OUT,  PC_PLUS4,  ALU_ADD,  ALU_ZERO, ALU_IMM, 0, 4));
        run_insn(32'h00001297, 1'b0, 0, mk("auipc", 1, WB_ALU_OUT,  PC_PLUS4,  ALU_ADD,  ALU_PC,   ALU_IMM, 0, 4));
        run_insn(32'h0080A283, 1'b0, 0, mk("lw_w0", 1, WB_MEM_LOAD, PC_PLUS4,  ALU_ADD,  ALU_RS1,  ALU_IMM, 0, 5));
`ifdef CTRL_PERF_CNT_EN
        check("minstret count", minstret_o, 64'd16);
`endif

        // Load whose data never arrives; reset lands while the request is pending.
        check("abort fetch_req", imem_req_o, 1'b1);
        dmem_delay    = 1000;
        instr_i       = 32'h0080A283;
        imem_rvalid_i = 1'b1;
        @(negedge clk);
        #1;
        imem_rvalid_i = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            #1;
            done = dmem_req_o;
        end
        check("abort reached_mem", done, 1'b1);
        rst = 1'b1;
        #1;
        check("abort dmem_req_dropped", dmem_req_o, 1'b0);
        check("abort no_pc_we", pc_we_o, 1'b0);
        do_reset("abort");

        run_trap("mul_f7", 32'h022081B3);
        run_trap("zero_insn", 32'h00000000);
        run_insn(32'h002081B3, 1'b0, 0, mk("add_after_trap", 1, WB_ALU_OUT, PC_PLUS4, ALU_ADD, ALU_RS1, ALU_RS2, 0, 4));

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
